// File: rtl/osd_bitmap_overlay.sv
// OSD bitmap overlay: follows the raster from hs/vs/de, fetches 1bpp bitmap bytes and
// replaces window pixels whose bit is set with a constant colour; 2-cycle aligned output.
module osd_bitmap_overlay #(
  parameter int OSD_X      = 64,
  parameter int OSD_Y      = 64,
  parameter int OSD_W      = 128,
  parameter int OSD_H      = 128,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int PIX_W      = 24,
  parameter int CNT_W      = 12,
  parameter logic [PIX_W-1:0] OSD_COLOR = 24'hFF0000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  osd_en,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [PIX_W-1:0]      i_data,
  output logic [ADDR_WIDTH-1:0] osd_rd_addr,
  input  logic [DATA_WIDTH-1:0] osd_rd_data,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [PIX_W-1:0]      o_data
);

  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [CNT_W-1:0]      X_LO    = CNT_W'(OSD_X);
  localparam logic [CNT_W-1:0]      X_HI    = CNT_W'(OSD_X + OSD_W);
  localparam logic [CNT_W-1:0]      Y_LO    = CNT_W'(OSD_Y);
  localparam logic [CNT_W-1:0]      Y_HI    = CNT_W'(OSD_Y + OSD_H);
  localparam logic [ADDR_WIDTH-1:0] BPL     = ADDR_WIDTH'(OSD_W / 8);

  logic [CNT_W-1:0]      x_cnt, y_cnt;
  logic [CNT_W-1:0]      x_off, y_off;
  logic                  en_frame, frame_ok;
  logic                  in_win, vs_rise, de_fall;
  logic [ADDR_WIDTH-1:0] rd_addr_next;

  logic                  hs_d, vs_d, de_d, in_win_d;
  logic [2:0]            bit_sel_d;
  logic [PIX_W-1:0]      data_d;
  logic                  osd_bit;

  always_comb begin
    vs_rise      = i_vs & ~vs_d;
    de_fall      = ~i_de & de_d;
    x_off        = x_cnt - X_LO;
    y_off        = y_cnt - Y_LO;
    in_win       = i_de & (x_cnt >= X_LO) & (x_cnt < X_HI) & (y_cnt >= Y_LO) & (y_cnt < Y_HI);
    rd_addr_next = ADDR_WIDTH'(y_off) * BPL + ADDR_WIDTH'(x_off[CNT_W-1:3]);
    osd_bit      = osd_rd_data[3'd7 - bit_sel_d];
  end

  // Raster tracking; a vs rising edge takes priority over the line increment.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      en_frame <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      if (i_de) begin
        if (x_cnt != CNT_MAX) x_cnt <= x_cnt + CNT_W'(1);
      end else if (de_d) begin
        x_cnt <= '0;
      end
      if (vs_rise) begin
        y_cnt    <= '0;
        en_frame <= osd_en;
        frame_ok <= 1'b1;
      end else if (de_fall && y_cnt != CNT_MAX) begin
        y_cnt <= y_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 0 -> 1: the address register also serves as the RAM's read address latch.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      osd_rd_addr <= '0;
      bit_sel_d   <= '0;
      in_win_d    <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      data_d      <= '0;
    end else begin
      if (in_win) osd_rd_addr <= rd_addr_next;
      bit_sel_d <= x_off[2:0];
      in_win_d  <= in_win;
      hs_d      <= i_hs;
      vs_d      <= i_vs;
      de_d      <= i_de;
      data_d    <= i_data;
    end
  end

  // Stage 1 -> 2
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      o_hs   <= hs_d;
      o_vs   <= vs_d;
      o_de   <= de_d;
      o_data <= (in_win_d & en_frame & frame_ok & osd_bit) ? OSD_COLOR : data_d;
    end
  end

endmodule

// File: tb/tb_osd_bitmap_overlay.sv
// Bench for osd_bitmap_overlay: random pixels and bitmap, reference computed from
// frame coordinates, window geometry and per-frame enable state.
module tb_osd_bitmap_overlay;

  localparam logic [23:0] COLOR = 24'hFF0000;

  logic        rd_clk = 1'b0;
  logic        rd_rst, osd_en, i_hs, i_vs, i_de;
  logic [23:0] i_data;
  logic [10:0] osd_rd_addr;
  logic [7:0]  osd_rd_data;
  logic        o_hs, o_vs, o_de;
  logic [23:0] o_data;

  logic [7:0]  ram [0:2047];

  // Bitmap RAM: address latched by the DUT, data valid the following cycle.
  assign osd_rd_data = ram[osd_rd_addr];

  always #5 rd_clk = ~rd_clk;

  osd_bitmap_overlay dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .osd_en      (osd_en),
    .i_hs        (i_hs),
    .i_vs        (i_vs),
    .i_de        (i_de),
    .i_data      (i_data),
    .osd_rd_addr (osd_rd_addr),
    .osd_rd_data (osd_rd_data),
    .o_hs        (o_hs),
    .o_vs        (o_vs),
    .o_de        (o_de),
    .o_data      (o_data)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          color_cnt;
  logic        en_m, ok_m, prev_vs;
  logic [10:0] addr_m;
  logic        p_valid, p_hs, p_vs, p_de;
  logic [23:0] p_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: x/y are the active pixel/line coordinates of this input.
  task automatic step(input logic hs, input logic vs, input logic de, input logic rst,
                      input int x, input int y);
    logic [23:0] d, exp_d;
    logic        win, bitv;
    d = 24'($urandom);
    if (d == COLOR) d = d ^ 24'h1;
    i_hs = hs; i_vs = vs; i_de = de; i_data = d; rd_rst = rst;
    if (rst) begin
      en_m = 1'b0; ok_m = 1'b0; addr_m = '0;
    end else if (vs && !prev_vs) begin
      en_m = osd_en; ok_m = 1'b1;
    end
    prev_vs = rst ? 1'b0 : vs;
    win = !rst && de && x >= 64 && x < 192 && y >= 64 && y < 192;
    if (win) addr_m = 11'((y - 64) * 16 + (x - 64) / 8);
    bitv  = win ? ram[addr_m][7 - ((x - 64) % 8)] : 1'b0;
    exp_d = (win && en_m && ok_m && bitv) ? COLOR : d;
    @(posedge rd_clk);
    #1;
    chk("rd_addr", 32'(osd_rd_addr), 32'(addr_m));
    if (de && y == 191 && (x == 191 || x == 192)) chk("addr_edge_x", 32'(osd_rd_addr), 32'd2047);
    if (de && y == 192 && x == 191)               chk("addr_edge_y", 32'(osd_rd_addr), 32'd2047);
    if (!rst && p_valid) begin
      chk("o_hs",   32'(o_hs),   32'(p_hs));
      chk("o_vs",   32'(o_vs),   32'(p_vs));
      chk("o_de",   32'(o_de),   32'(p_de));
      chk("o_data", 32'(o_data), 32'(p_data));
    end
    if (o_de && o_data === COLOR) color_cnt++;
    p_valid = !rst;
    p_hs = hs; p_vs = vs; p_de = de; p_data = exp_d;
  endtask

  // rst_after: pulse reset in the blanking after that line; en_off_line: drop osd_en there.
  task automatic frame(input int nl, input int np, input int rst_after, input int en_off_line);
    color_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      int y;
      y = (rst_after >= 0 && l > rst_after) ? l - rst_after - 1 : l;
      if (l == en_off_line) osd_en = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int x = 0; x < np; x++) step(1'b0, 1'b0, 1'b1, 1'b0, x, y);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, l == rst_after, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 2048; a++) ram[a] = 8'($urandom);
  endtask

  task automatic fill_ones();
    for (int a = 0; a < 2048; a++) ram[a] = 8'hFF;
  endtask

  initial begin
    en_m = 1'b0; ok_m = 1'b0; prev_vs = 1'b0; addr_m = '0;
    p_valid = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0; p_data = '0;
    color_cnt = 0;
    osd_en = 1'b0;
    fill_random();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("rst_o_hs",   32'(o_hs),        32'd0);
    chk("rst_o_vs",   32'(o_vs),        32'd0);
    chk("rst_o_de",   32'(o_de),        32'd0);
    chk("rst_o_data", 32'(o_data),      32'd0);
    chk("rst_addr",   32'(osd_rd_addr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Byte 0 = A5 on the first window line
    osd_en = 1'b1;
    ram[0] = 8'hA5;
    frame(66, 84, -1, -1);

    // Full window, right/bottom edges
    fill_random();
    frame(194, 196, -1, -1);

    // Enable dropped mid-frame: the whole frame is still overlaid
    fill_ones();
    osd_en = 1'b1;
    frame(66, 84, -1, 10);
    chk("color_after_en_drop", 32'(color_cnt), 32'd40);

    // Disabled frame: pure pass-through
    fill_random();
    frame(66, 84, -1, -1);
    chk("color_disabled", 32'(color_cnt), 32'd0);

    // Reset after window line 64: line 65 must not be overlaid
    fill_ones();
    osd_en = 1'b1;
    frame(66, 84, 64, -1);
    chk("color_after_reset", 32'(color_cnt), 32'd20);

    // Bytes 0,1 = 80,01: colour only at x=64 and x=79
    fill_random();
    ram[0] = 8'h80; ram[1] = 8'h01; ram[2] = 8'h00;
    ram[16] = 8'h00; ram[17] = 8'h00; ram[18] = 8'h00;
    frame(66, 84, -1, -1);
    chk("color_edge_bits", 32'(color_cnt), 32'd2);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
